// File: rtl/iir_sos_pkg.sv
// Shared definitions for the biquad-cascade scheduler: FSM states, tap codes,
// registered strobe bundle and a width helper.
package iir_sos_pkg;
    localparam int MAC_PHASES = 5;
    localparam int PH_W       = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_SCALE_IN, S_MAC, S_SEC_SCALE, S_DONE, S_FLUSH
    } state_t;

    // MAC phase number doubles as the datapath tap select
    typedef enum logic [PH_W-1:0] {
        TAP_X = 3'd0, TAP_X1 = 3'd1, TAP_X2 = 3'd2, TAP_Y1 = 3'd3, TAP_Y2 = 3'd4
    } tap_e;

    typedef struct packed {
        logic acc_clr;
        logic acc_en;
        logic scale_en;
        logic sec_done;
        logic state_clr;
        logic out_valid;
        logic busy;
    } strobe_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/iir_sos_scheduler_if.sv
// Sample handshake plus datapath control bundle between scheduler and IIR datapath.
interface iir_sos_scheduler_if #(
    parameter int NUM_SOS = 4,
    parameter int CNT_W   = 16
);
    import iir_sos_pkg::*;
    localparam int SEC_W   = clog2(NUM_SOS);
    localparam int COEF_AW = clog2(NUM_SOS * MAC_PHASES);
    localparam int SCALE_W = clog2(NUM_SOS + 1);

    logic               in_valid, in_ready, flush, ovf_in, sample_load;
    logic [SEC_W-1:0]   sec_idx;
    logic [COEF_AW-1:0] coef_addr;
    logic [2:0]         tap_sel;
    logic               acc_clr, acc_en, scale_en;
    logic [SCALE_W-1:0] scale_sel;
    logic               sec_done, state_clr, out_valid, busy, ovf_flag;
    logic [CNT_W-1:0]   sample_cnt;

    modport master (
        input  in_valid, flush, ovf_in,
        output in_ready, sample_load, sec_idx, coef_addr, tap_sel, acc_clr, acc_en,
               scale_en, scale_sel, sec_done, state_clr, out_valid, busy, ovf_flag,
               sample_cnt
    );
    modport slave (
        output in_valid, flush, ovf_in,
        input  in_ready, sample_load, sec_idx, coef_addr, tap_sel, acc_clr, acc_en,
               scale_en, scale_sel, sec_done, state_clr, out_valid, busy, ovf_flag,
               sample_cnt
    );
endinterface

// File: rtl/sos_sequence_counter.sv
// Nested section/phase counter. Exposes next-cycle values so the top can
// register its outputs without an extra cycle of latency.
module sos_sequence_counter import iir_sos_pkg::*; #(
    parameter int NUM_SOS = 4,
    parameter int SEC_W   = 2,
    parameter int COEF_AW = 5
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               load,
    input  logic               adv_ph,
    input  logic               adv_sec,
    output logic [SEC_W-1:0]   sec_d,
    output logic [PH_W-1:0]    ph_d,
    output logic [COEF_AW-1:0] coef_d,
    output logic               last_phase,
    output logic               last_section
);
    logic [SEC_W-1:0] sec_q;
    logic [PH_W-1:0]  ph_q;

    assign last_phase   = (ph_q == TAP_Y2);
    assign last_section = (sec_q == SEC_W'(NUM_SOS - 1));

    always_comb begin
        sec_d = sec_q;
        ph_d  = ph_q;
        if (load) begin
            sec_d = '0;
            ph_d  = '0;
        end else if (adv_sec) begin
            sec_d = sec_q + SEC_W'(1);
            ph_d  = '0;
        end else if (adv_ph) begin
            ph_d = ph_q + PH_W'(1);
        end
    end

    assign coef_d = COEF_AW'(sec_d) * COEF_AW'(MAC_PHASES) + COEF_AW'(ph_d);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            sec_q <= '0;
            ph_q  <= '0;
        end else begin
            sec_q <= sec_d;
            ph_q  <= ph_d;
        end
    end
endmodule

// File: rtl/iir_sos_scheduler.sv
// Time-multiplexed biquad cascade sequencer: input scale, 5 MAC phases and a
// scale/writeback per section, then an output pulse. Outputs are registered.
module iir_sos_scheduler import iir_sos_pkg::*; #(
    parameter int NUM_SOS = 4,
    parameter int CNT_W   = 16
) (
    input logic CLK,
    input logic Reset,
    iir_sos_scheduler_if.master bus
);
    localparam int SEC_W   = clog2(NUM_SOS);
    localparam int COEF_AW = clog2(NUM_SOS * MAC_PHASES);
    localparam int SCALE_W = clog2(NUM_SOS + 1);

    state_t state, ns;
    logic flush_pend, ovf_q, hs, flush_last;
    logic cnt_load, adv_ph, adv_sec, last_phase, last_section;
    logic [SEC_W-1:0]   sec_d, sec_idx_d, sec_idx_q;
    logic [PH_W-1:0]    ph_d, tap_d, tap_q;
    logic [COEF_AW-1:0] coef_d, coef_nx, coef_q;
    logic [SCALE_W-1:0] scale_sel_d, scale_sel_q;
    logic [CNT_W-1:0]   cnt_q;
    strobe_t stb_d, stb_q;

    assign bus.in_ready    = (state == S_IDLE || state == S_DONE) && !bus.flush && !flush_pend;
    assign hs              = bus.in_valid && bus.in_ready;
    assign bus.sample_load = hs;
    assign flush_last      = (state == S_FLUSH) && last_section;

    sos_sequence_counter #(.NUM_SOS(NUM_SOS), .SEC_W(SEC_W), .COEF_AW(COEF_AW)) u_seq (
        .CLK(CLK), .Reset(Reset), .load(cnt_load), .adv_ph(adv_ph), .adv_sec(adv_sec),
        .sec_d(sec_d), .ph_d(ph_d), .coef_d(coef_d),
        .last_phase(last_phase), .last_section(last_section)
    );

    always_ff @(posedge CLK) begin
        if (Reset) state <= S_IDLE;
        else       state <= ns;
    end

    always_comb begin
        ns = state; cnt_load = 1'b0; adv_ph = 1'b0; adv_sec = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.flush)  begin ns = S_FLUSH;    cnt_load = 1'b1; end
                else if (hs)    begin ns = S_SCALE_IN; cnt_load = 1'b1; end
            end
            S_SCALE_IN:  ns = S_MAC;
            S_MAC: begin
                if (last_phase) ns = S_SEC_SCALE;
                else            adv_ph = 1'b1;
            end
            S_SEC_SCALE: begin
                if (last_section) ns = S_DONE;
                else begin ns = S_MAC; adv_sec = 1'b1; end
            end
            // pending flush wins over a new sample once the current one drains
            S_DONE: begin
                if (bus.flush || flush_pend) begin ns = S_FLUSH; cnt_load = 1'b1; end
                else if (hs) begin ns = S_SCALE_IN; cnt_load = 1'b1; end
                else ns = S_IDLE;
            end
            S_FLUSH: begin
                if (last_section) ns = S_IDLE;
                else              adv_sec = 1'b1;
            end
            default: ns = S_IDLE;
        endcase

        stb_d = '0; sec_idx_d = '0; coef_nx = '0; tap_d = '0; scale_sel_d = '0;
        stb_d.busy = (ns != S_IDLE);
        case (ns)
            S_SCALE_IN: stb_d.scale_en = 1'b1;
            S_MAC: begin
                stb_d.acc_en  = 1'b1;
                stb_d.acc_clr = (ph_d == TAP_X);
                tap_d         = ph_d;
                coef_nx       = coef_d;
                sec_idx_d     = sec_d;
            end
            S_SEC_SCALE: begin
                stb_d.scale_en = 1'b1;
                stb_d.sec_done = 1'b1;
                scale_sel_d    = SCALE_W'(sec_d) + SCALE_W'(1);
                sec_idx_d      = sec_d;
            end
            S_DONE:  stb_d.out_valid = 1'b1;
            S_FLUSH: begin
                stb_d.state_clr = 1'b1;
                sec_idx_d       = sec_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stb_q <= '0; sec_idx_q <= '0; coef_q <= '0; tap_q <= '0; scale_sel_q <= '0;
            flush_pend <= 1'b0; ovf_q <= 1'b0; cnt_q <= '0;
        end else begin
            stb_q <= stb_d; sec_idx_q <= sec_idx_d; coef_q <= coef_nx;
            tap_q <= tap_d; scale_sel_q <= scale_sel_d;
            if (flush_last)                          flush_pend <= 1'b0;
            else if (bus.flush && state != S_IDLE)   flush_pend <= 1'b1;
            if (flush_last)                          ovf_q <= 1'b0;
            else if (bus.ovf_in && state != S_IDLE)  ovf_q <= 1'b1;
            if (ns == S_DONE) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.acc_clr    = stb_q.acc_clr;
    assign bus.acc_en     = stb_q.acc_en;
    assign bus.scale_en   = stb_q.scale_en;
    assign bus.sec_done   = stb_q.sec_done;
    assign bus.state_clr  = stb_q.state_clr;
    assign bus.out_valid  = stb_q.out_valid;
    assign bus.busy       = stb_q.busy;
    assign bus.sec_idx    = sec_idx_q;
    assign bus.coef_addr  = coef_q;
    assign bus.tap_sel    = tap_q;
    assign bus.scale_sel  = scale_sel_q;
    assign bus.ovf_flag   = ovf_q;
    assign bus.sample_cnt = cnt_q;
endmodule

// File: tb/tb_iir_sos_scheduler.sv
// Bench for iir_sos_scheduler: directed timelines plus an out_valid scoreboard.
module tb_iir_sos_scheduler;
    logic CLK = 1'b0;
    logic Reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   sbq[$];
    int   T;

    iir_sos_scheduler_if #(.NUM_SOS(4), .CNT_W(16)) bus();
    iir_sos_scheduler #(.NUM_SOS(4), .CNT_W(16)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        @(negedge CLK);
        while (cyc < c) @(negedge CLK);
    endtask

    // scoreboard: each accepted sample queues the cycle its out_valid is due
    always @(negedge CLK) begin
        logic exp_ov;
        exp_ov = (sbq.size() > 0) && (sbq[0] == cyc);
        if (exp_ov) void'(sbq.pop_front());
        if (exp_ov || bus.out_valid) chk("out_valid", bus.out_valid, exp_ov);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.ovf_in = 1'b0;
        wait_cyc(2);
        Reset = 1'b0;
        wait_cyc(3);
        chk("rst_busy", bus.busy, 0);
        chk("rst_coef", bus.coef_addr, 0);
        chk("rst_cnt", bus.sample_cnt, 0);
        chk("rst_ovf", bus.ovf_flag, 0);
        chk("rst_ready", bus.in_ready, 1);

        // single sample timeline
        T = cyc + 1; wait_cyc(T);
        bus.in_valid = 1'b1; #1;
        chk("s1_load", bus.sample_load, 1); sbq.push_back(T + 26);
        wait_cyc(T + 1); bus.in_valid = 1'b0;
        chk("s1_scale_en", bus.scale_en, 1);
        chk("s1_scale_sel0", bus.scale_sel, 0);
        for (int k = 0; k < 5; k++) begin
            wait_cyc(T + 2 + k);
            chk("s1_coef", bus.coef_addr, k);
            chk("s1_tap", bus.tap_sel, k);
            chk("s1_acc_clr", bus.acc_clr, (k == 0));
            chk("s1_acc_en", bus.acc_en, 1);
        end
        wait_cyc(T + 7);
        chk("s1_sec_done", bus.sec_done, 1);
        chk("s1_scale_sel1", bus.scale_sel, 1);
        wait_cyc(T + 10);
        chk("s1_ready_busy", bus.in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            wait_cyc(T + 20 + k);
            chk("s1_coef_s3", bus.coef_addr, 15 + k);
            chk("s1_sec3", bus.sec_idx, 3);
        end
        wait_cyc(T + 25);
        chk("s1_scale_sel4", bus.scale_sel, 4);
        wait_cyc(T + 27);
        chk("s1_cnt", bus.sample_cnt, 1);
        chk("s1_idle", bus.busy, 0);

        // continuous in_valid: one handshake every 26 cycles
        T = cyc + 1; wait_cyc(T);
        bus.in_valid = 1'b1;
        for (int k = 0; k <= 52; k++) begin
            if (k > 0) wait_cyc(T + k);
            #1;
            chk("bb_ready", bus.in_ready, (k % 26 == 0));
            chk("bb_load", bus.sample_load, (k % 26 == 0));
            if (k % 26 == 0) sbq.push_back(T + k + 26);
        end
        wait_cyc(T + 53); bus.in_valid = 1'b0;
        wait_cyc(T + 79);
        chk("bb_cnt", bus.sample_cnt, 4);

        // overflow sticky across samples, flush while busy
        T = cyc + 1; wait_cyc(T);
        bus.in_valid = 1'b1; sbq.push_back(T + 26);
        wait_cyc(T + 12); bus.ovf_in = 1'b1;
        wait_cyc(T + 13); bus.ovf_in = 1'b0;
        chk("ovf_set", bus.ovf_flag, 1);
        wait_cyc(T + 26); #1;
        chk("ovf_b2b_load", bus.sample_load, 1); sbq.push_back(T + 52);
        wait_cyc(T + 27); bus.in_valid = 1'b0;
        wait_cyc(T + 36); bus.flush = 1'b1;
        wait_cyc(T + 37); bus.flush = 1'b0;
        chk("ovf_hold", bus.ovf_flag, 1);
        wait_cyc(T + 52); bus.in_valid = 1'b1; #1;
        chk("fl_ready_done", bus.in_ready, 0);
        chk("fl_no_load", bus.sample_load, 0);
        for (int k = 0; k < 4; k++) begin
            wait_cyc(T + 53 + k);
            chk("fl_clr", bus.state_clr, 1);
            chk("fl_sec", bus.sec_idx, k);
            chk("fl_no_ready", bus.in_ready, 0);
        end
        wait_cyc(T + 57); #1;
        chk("fl_ready", bus.in_ready, 1);
        chk("fl_ovf_clr", bus.ovf_flag, 0);
        chk("fl_load", bus.sample_load, 1); sbq.push_back(T + 83);
        wait_cyc(T + 58); bus.in_valid = 1'b0;
        wait_cyc(T + 84);
        chk("fl_cnt", bus.sample_cnt, 7);
        bus.ovf_in = 1'b1;
        wait_cyc(T + 85); bus.ovf_in = 1'b0;
        chk("ovf_idle_ign", bus.ovf_flag, 0);

        // flush and in_valid together in IDLE
        T = cyc + 1; wait_cyc(T);
        bus.flush = 1'b1; bus.in_valid = 1'b1; #1;
        chk("fi_no_load", bus.sample_load, 0);
        for (int k = 0; k < 4; k++) begin
            wait_cyc(T + 1 + k);
            bus.flush = 1'b0;
            chk("fi_clr", bus.state_clr, 1);
            chk("fi_sec", bus.sec_idx, k);
        end
        wait_cyc(T + 5); #1;
        chk("fi_load", bus.sample_load, 1); sbq.push_back(T + 31);
        wait_cyc(T + 6); bus.in_valid = 1'b0;
        wait_cyc(T + 32);
        chk("fi_cnt", bus.sample_cnt, 8);

        // reset mid-sample discards it
        T = cyc + 1; wait_cyc(T);
        bus.in_valid = 1'b1; #1;
        chk("rs_load", bus.sample_load, 1);
        wait_cyc(T + 1); bus.in_valid = 1'b0;
        wait_cyc(T + 15); Reset = 1'b1;
        wait_cyc(T + 16); Reset = 1'b0;
        chk("rs_busy", bus.busy, 0);
        chk("rs_acc_en", bus.acc_en, 0);
        chk("rs_coef", bus.coef_addr, 0);
        chk("rs_sec", bus.sec_idx, 0);
        chk("rs_cnt", bus.sample_cnt, 0);
        bus.in_valid = 1'b1; #1;
        chk("rs_reload", bus.sample_load, 1); sbq.push_back(T + 42);
        wait_cyc(T + 17); bus.in_valid = 1'b0;
        wait_cyc(T + 43);
        chk("rs_cnt_after", bus.sample_cnt, 1);

        wait_cyc(cyc + 3);
        chk("sb_left", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/iir_sos_scheduler.md
Name: iir_sos_scheduler

Overview:
Control sequencer for a time-multiplexed fixed-point IIR biquad datapath: one shared MAC and one scale multiplier serve all NUM_SOS second-order sections. The block accepts one input sample per handshake and steps the datapath through input scaling, 5 MAC phases per section, and a per-section scale/writeback. It then flags the filtered output. It sits between the sample source and the IIR datapath, driving coefficient ROM addresses, tap selects, accumulator controls and delay-line writeback.

Parameters:
NUM_SOS, 4, number of cascaded second-order sections
MAC_PHASES, 5, MAC cycles per section (b0, b1, b2, a1, a2); fixed, not overridable
SEC_W, 2, width of section index, equal to clog2(NUM_SOS)
COEF_AW, 5, coefficient address width, equal to clog2(NUM_SOS*MAC_PHASES)
SCALE_W, 3, scale-value index width, equal to clog2(NUM_SOS+1)
CNT_W, 16, width of processed-sample counter

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
in_valid  in  1  input sample available
in_ready  out  1  scheduler can accept a sample
flush  in  1  request to clear all section delay lines
ovf_in  in  1  datapath overflow strobe
sample_load  out  1  datapath latches input sample (in_valid & in_ready)
sec_idx  out  SEC_W  active section
coef_addr  out  COEF_AW  sec_idx*5 + phase
tap_sel  out  3  0=x, 1=x[n-1], 2=x[n-2], 3=y[n-1], 4=y[n-2]
acc_clr  out  1  accumulator load instead of add (phase 0)
acc_en  out  1  accumulator update
scale_en  out  1  scale multiplier active
scale_sel  out  SCALE_W  scale-value index 0..NUM_SOS
sec_done  out  1  shift delay line of sec_idx; section result feeds next section
state_clr  out  1  zero delay line of sec_idx
out_valid  out  1  one-cycle pulse: filter output valid
busy  out  1  high outside IDLE
ovf_flag  out  1  sticky overflow
sample_cnt  out  CNT_W  outputs produced, wraps

Behaviour:
- Reset (any cycle, mid-sample included): state=IDLE; all strobes, sec_idx, coef_addr, tap_sel, scale_sel, ovf_flag and sample_cnt are 0; pending flush is dropped; an in-flight sample is discarded with no out_valid.
- States: IDLE, SCALE_IN, MAC, SEC_SCALE, DONE, FLUSH.
- in_ready = (IDLE or DONE) and not flush and not flush_pending. Handshake in cycle T goes to SCALE_IN at T+1.
- SCALE_IN: scale_en=1, scale_sel=0, sec_idx=0. Next state is MAC with phase=0.
- MAC: acc_en=1; acc_clr=1 only at phase 0; tap_sel=phase; coef_addr=sec_idx*5+phase. Phase 4 goes to SEC_SCALE.
- SEC_SCALE: scale_en=1, scale_sel=sec_idx+1, sec_done=1. If sec_idx=NUM_SOS-1, go to DONE; otherwise sec_idx+1 and MAC phase 0.
- DONE: out_valid=1 for one cycle, sample_cnt+1 (wraps at 2^CNT_W). If a handshake occurs here, go to SCALE_IN; else go to IDLE.
- Latency from handshake at T to out_valid: 2+6*NUM_SOS cycles (26 at default). Back-to-back throughput is one sample per 26 cycles.
- flush in IDLE/DONE: goes to FLUSH and takes priority over in_valid. flush while busy sets flush_pending, which is serviced after DONE instead of accepting a sample.
- FLUSH: NUM_SOS cycles with state_clr=1 and sec_idx=0..NUM_SOS-1. The final cycle clears ovf_flag and flush_pending. Then goes to IDLE.
- ovf_flag: set when ovf_in=1 while busy. Cleared only by Reset or flush completion. ovf_in in IDLE is ignored.
- Outputs are registered except sample_load and in_ready. Strobes are 0 in states not listed.

Decomposition:
- Shared package iir_sos_pkg:
  - state encoding
  - phase/tap codes (TAP_X..TAP_Y2)
  - MAC_PHASES=5
  - clog2 helper for SEC_W/COEF_AW/SCALE_W
- Sub-module sos_sequence_counter: nested section/phase counter with load, advance, last_phase and last_section flags, and coef_addr generation.
- The FSM, handshake and flush logic stay in the top module.

Test Plan:
- Single sample: in_valid at T → sample_load@T, scale_sel=0@T+1, coef_addr 0..4@T+2..T+6, sec_done+scale_sel=1@T+7, coef_addr 15..19@T+20..T+24, out_valid@T+26, sample_cnt=1.
- Continuous in_valid over 3 samples → handshakes at T, T+26, T+52; out_valid at T+26, T+52, T+78; in_ready low elsewhere.
- flush asserted at T+10 during a sample → out_valid@T+26, no handshake at T+26, state_clr with sec_idx 0,1,2,3 at T+27..T+30, in_ready high at T+31.
- ovf_in pulsed at T+12 → ovf_flag=1 from T+13, stays set through following samples, cleared after flush completes.
- Reset at T+15 mid-sample → all outputs 0 at T+16, no out_valid, sample_cnt unchanged at 0, next handshake processes normally (26-cycle latency).
- flush and in_valid together in IDLE → FLUSH runs, sample_load=0; sample accepted the cycle after FLUSH exits.
